// File: rtl/benes_stream_bridge.sv
// Beat buffer between the AXI4 W/R paths and a fixed-latency Benes permutation core.
// Optional statistics counters are enabled by defining BENES_BRIDGE_STATS_EN.
module benes_stream_bridge #(
    parameter int DATA_W    = 512,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8,
    parameter int LAT       = 4
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              core_in_valid,
    output logic [DATA_W-1:0] core_in_data,
    input  logic              core_out_valid,
    input  logic [DATA_W-1:0] core_out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              burst_done,
    output logic              seq_err,
    output logic [31:0]       stat_beats_in,
    output logic [31:0]       stat_beats_out,
    output logic [31:0]       stat_stall
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int ICW = $clog2(IN_DEPTH + 1);
    localparam int OCW = $clog2(OUT_DEPTH + 1);
    localparam int IFW = $clog2(LAT + 2);
    localparam int BW  = $clog2(LAT + 1);

    logic [DATA_W:0]   in_mem_q [IN_DEPTH];
    logic [IAW-1:0]    in_wp_q, in_rp_q;
    logic [ICW-1:0]    in_cnt_q, in_cnt_d;
    logic              in_ready_q;
    logic [DATA_W:0]   out_mem_q [OUT_DEPTH];
    logic [OAW-1:0]    out_wp_q, out_rp_q, out_rp_nxt_s;
    logic [OCW-1:0]    out_cnt_q, out_cnt_d;
    logic              out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic              core_in_valid_q;
    logic [DATA_W-1:0] core_in_data_q;
    logic [LAT:0]      tag_v_q, tag_l_q;
    logic [BW-1:0]     blank_q;
    logic              seq_err_q, burst_done_q;

    logic              in_push_s, issue_s, credit_s, out_push_s, out_pop_s, seq_err_s;
    logic [IFW-1:0]    inflight_s;
    logic [DATA_W:0]   in_head_s, out_head_s;

    // Handshakes, credit check, next counts and the next output head
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i <= LAT; i++) begin
            inflight_s = inflight_s + IFW'(tag_v_q[i]);
        end
        in_push_s  = in_valid & in_ready_q;
        in_head_s  = in_mem_q[in_rp_q];
        credit_s   = (32'(out_cnt_q) + 32'(inflight_s)) < 32'(OUT_DEPTH);
        issue_s    = (in_cnt_q != '0) & credit_s;
        in_cnt_d   = in_cnt_q + ICW'(in_push_s) - ICW'(issue_s);
        out_push_s = tag_v_q[LAT];
        out_pop_s  = out_valid_q & out_ready;
        out_cnt_d  = out_cnt_q + OCW'(out_push_s) - OCW'(out_pop_s);
        out_rp_nxt_s = out_rp_q + OAW'(out_pop_s);
        // A push into a FIFO that will otherwise be empty becomes the new head directly
        if (out_push_s && (out_cnt_q == OCW'(out_pop_s))) begin
            out_head_s = {tag_l_q[LAT], core_out_data};
        end else begin
            out_head_s = out_mem_q[out_rp_nxt_s];
        end
        seq_err_s = (blank_q == '0) & (tag_v_q[LAT] != core_out_valid);
    end

    // FIFO storage writes; contents are don't-care while the counts say empty
    always_ff @(posedge s00_axi_aclk) begin
        if (in_push_s) begin
            in_mem_q[in_wp_q] <= {in_last, in_data};
        end
        if (out_push_s) begin
            out_mem_q[out_wp_q] <= {tag_l_q[LAT], core_out_data};
        end
    end

    // Pointers, counts, tag pipe, registered outputs and sticky error
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            in_wp_q         <= '0;
            in_rp_q         <= '0;
            in_cnt_q        <= '0;
            in_ready_q      <= 1'b0;
            out_wp_q        <= '0;
            out_rp_q        <= '0;
            out_cnt_q       <= '0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            out_data_q      <= '0;
            core_in_valid_q <= 1'b0;
            core_in_data_q  <= '0;
            tag_v_q         <= '0;
            tag_l_q         <= '0;
            blank_q         <= BW'(LAT);
            seq_err_q       <= 1'b0;
            burst_done_q    <= 1'b0;
        end else begin
            in_wp_q         <= in_wp_q + IAW'(in_push_s);
            in_rp_q         <= in_rp_q + IAW'(issue_s);
            in_cnt_q        <= in_cnt_d;
            in_ready_q      <= (in_cnt_d != ICW'(IN_DEPTH));
            core_in_valid_q <= issue_s;
            if (issue_s) begin
                core_in_data_q <= in_head_s[DATA_W-1:0];
            end
            tag_v_q         <= {tag_v_q[LAT-1:0], issue_s};
            tag_l_q         <= {tag_l_q[LAT-1:0], issue_s & in_head_s[DATA_W]};
            out_wp_q        <= out_wp_q + OAW'(out_push_s);
            out_rp_q        <= out_rp_nxt_s;
            out_cnt_q       <= out_cnt_d;
            out_valid_q     <= (out_cnt_d != '0);
            if (out_cnt_d != '0) begin
                out_data_q <= out_head_s[DATA_W-1:0];
                out_last_q <= out_head_s[DATA_W];
            end
            burst_done_q    <= out_pop_s & out_last_q;
            if (blank_q != '0) begin
                blank_q <= blank_q - BW'(1);
            end
            if (seq_err_s) begin
                seq_err_q <= 1'b1;
            end
        end
    end

`ifdef BENES_BRIDGE_STATS_EN
    logic [31:0] st_in_q, st_out_q, st_stall_q;

    // Free-running wrap-around statistics
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            st_in_q    <= 32'd0;
            st_out_q   <= 32'd0;
            st_stall_q <= 32'd0;
        end else begin
            st_in_q    <= st_in_q + 32'(in_push_s);
            st_out_q   <= st_out_q + 32'(out_pop_s);
            st_stall_q <= st_stall_q + 32'((in_cnt_q != '0) & !credit_s);
        end
    end

    assign stat_beats_in  = st_in_q;
    assign stat_beats_out = st_out_q;
    assign stat_stall     = st_stall_q;
`else
    assign stat_beats_in  = 32'd0;
    assign stat_beats_out = 32'd0;
    assign stat_stall     = 32'd0;
`endif

    assign in_ready      = in_ready_q;
    assign core_in_valid = core_in_valid_q;
    assign core_in_data  = core_in_data_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_last      = out_last_q;
    assign burst_done    = burst_done_q;
    assign seq_err       = seq_err_q;
endmodule
